dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port Y86 data memory (256 x 64-bit words, 2048 bytes) between two requesters.
//  Port M is the pipeline memory-access stage; port L is the program loader / debug port.
//  Performs fixed M-priority arbitration with a starvation bound for L, plus out-of-range
//  address checking. Returns exactly one registered response per granted request.
//  Sits between the memory-access logic and the data RAM; the RAM itself is outside this block.
// PARAMETERS
//  MEM_BYTES  2048  addressable bytes; the legal address range is 0..MEM_BYTES-1
//  IDX_W      8     RAM word-index width; mem_idx_o = addr[IDX_W+2:3]
//  RD_LAT     1     RAM read latency in cycles (>=1); mem_rdata_i is valid RD_LAT cycles after mem_en_o
//  MAX_WAIT   4     L-starved IDLE cycles before L overrides M (0 = L always has priority)
// PORTS
//  clk_i        in   1      clock, rising edge
//  rst_i        in   1      synchronous reset, active-high
//  m_req_i      in   1      M request; must stay asserted with stable fields until m_gnt_o
//  m_we_i       in   1      M: 1 = write, 0 = read
//  m_addr_i     in   64     M byte address
//  m_wdata_i    in   64     M write data
//  m_gnt_o      out  1      M request accepted this cycle (combinational)
//  m_rvalid_o   out  1      M response pulse (registered)
//  m_rdata_o    out  64     M read data; 0 for writes and errors
//  m_err_o      out  1      M address error; valid with m_rvalid_o
//  l_*          -    -      same set as m_* for port L (l_req_i .. l_err_o)
//  mem_en_o     out  1      RAM access strobe
//  mem_we_o     out  1      RAM write enable
//  mem_idx_o    out  IDX_W  RAM word index
//  mem_wdata_o  out  64     RAM write data
//  mem_rdata_i  in   64     RAM read data
//  busy_o       out  1      1 while state == WAIT
// BEHAVIOUR
//  Reset: state=IDLE, starvation counter=0. All *_rvalid_o, *_err_o, *_rdata_o, busy_o = 0.
//   Grants and mem_* outputs are 0 in the reset cycle.
//  FSM IDLE:
//   Grant at most one request per cycle (cycle T).
//   Priority is M, unless starve_cnt >= MAX_WAIT, in which case priority is L.
//   On a grant, drive mem_* combinationally in cycle T and go to WAIT with lat_cnt = RD_LAT.
//  FSM WAIT:
//   No grants. lat_cnt decrements each cycle.
//   In cycle T+RD_LAT, capture mem_rdata_i (reads only), then return to IDLE.
//  Response: owner's rvalid is high for exactly one cycle at T+RD_LAT+1.
//   A new grant may occur in that same cycle, giving a throughput of 1 request per RD_LAT+1 cycles.
//  Writes: the RAM write happens in cycle T. The response follows the same timing as a read,
//   with rdata = 0.
//  Address error: addr > MEM_BYTES-1.
//   The request is still granted and follows the WAIT timing, but mem_en_o and mem_we_o stay 0.
//   The response has err = 1 and rdata = 0.
//   Low address bits [2:0] are ignored, with no alignment error.
//  Starvation counter: in IDLE, +1 each cycle that l_req_i=1 and l_gnt_o=0, saturating at MAX_WAIT.
//   Cleared on an L grant. Held in WAIT.
//  Both requests present with starve_cnt < MAX_WAIT: grant M.
//   With MAX_WAIT=4, L is granted no later than its 5th IDLE cycle.
//  Request dropped before grant: ignored, no response. Protocol violation; the bench flags it.
//  Reset during WAIT: return to IDLE and discard the pending response (no rvalid).
//   A write already issued in cycle T stays committed.
// STRUCTURE
//  y86_dmem_pkg: state encoding (IDLE, WAIT), owner encoding (OWN_M, OWN_L), MEM_BYTES/IDX_W defaults.
//  Sub-module dmem_prio_sel: starvation counter plus priority decision, outputs grant_m and grant_l.
//  Top level: FSM, latency counter, owner/err registers, RAM mux, response registers.
// TESTING
//  1 M read addr 0x10 (RAM word 2 = 0xAB), RD_LAT=1: gnt at T, mem_idx_o=2, m_rvalid_o with rdata 0xAB at T+2.
//  2 M write 0x55 to 0x7F8, then M read 0x7F8: idx=255, second response rdata=0x55, err=0.
//  3 L read 0x800: granted, mem_en_o never 1, l_rvalid_o at T+2 with err=1, rdata=0.
//  4 M and L requesting continuously, MAX_WAIT=4: L granted within <=5 IDLE cycles; M never starved >1 slot.
//  5 M read granted, rst_i in WAIT: no m_rvalid_o, busy_o=0, state IDLE on the next cycle.
//  6 RD_LAT=3, back-to-back M reads: grants spaced 4 cycles; each rvalid coincides with the next grant.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the FSM state and response-owner encodings, default memory geometry,
// and the address range check used when a request is granted.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W        = 64;
  localparam int unsigned MEM_BYTES_DEF = 2048;
  localparam int unsigned IDX_W_DEF     = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_M = 1'b0,
    OWN_L = 1'b1
  } owner_e;

  // A byte address is legal when it lies in 0..mem_bytes-1; low bits are not checked.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned mem_bytes);
    return (addr < 64'(mem_bytes));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
//   master : requester side (drives req/we/addr/wdata, receives gnt/rvalid/rdata/err)
//   slave  : arbiter side
// req must stay high with stable fields until gnt; rvalid is a one-cycle
// response pulse carrying rdata and err.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [63:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_arbiter_prio_sel.sv
// Priority decision for the data-memory arbiter.
// M wins by default; once L has been refused MAX_WAIT idle cycles in a row,
// L wins instead. The starvation counter only moves while the arbiter is idle.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   idle_i         : arbiter is able to grant this cycle
//   m_req_i/l_req_i: pending requests
//   grant_m_o/l_o  : at most one is high (combinational)
module dmem_prio_sel #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic m_req_i,
  input  logic l_req_i,
  output logic grant_m_o,
  output logic grant_l_o
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved_s;

  // Grant decision; nothing is granted while in reset or outside IDLE.
  always_comb begin
    starved_s = (starve_q >= CNT_W'(MAX_WAIT));
    grant_m_o = 1'b0;
    grant_l_o = 1'b0;
    if (idle_i && !rst_i) begin
      if (l_req_i && (starved_s || !m_req_i)) begin
        grant_l_o = 1'b1;
      end else if (m_req_i) begin
        grant_m_o = 1'b1;
      end else begin
        grant_l_o = 1'b0;
      end
    end else begin
      grant_m_o = 1'b0;
    end
  end

  // Starvation count: cleared on an L grant, saturates at MAX_WAIT, held when not idle.
  always_comb begin
    starve_d = starve_q;
    if (grant_l_o) begin
      starve_d = {CNT_W{1'b0}};
    end else if (idle_i && l_req_i && !starved_s) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= {CNT_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the pipeline memory stage (M)
// and the loader/debug port (L).
//   clk_i, rst_i   : clock, synchronous active-high reset
//   m_if, l_if     : requester ports (slave side)
//   mem_en_o/we_o  : RAM strobe and write enable, driven in the grant cycle
//   mem_idx_o      : RAM word index (byte address bits [IDX_W+2:3])
//   mem_wdata_o    : RAM write data
//   mem_rdata_i    : RAM read data, valid RD_LAT cycles after mem_en_o
//   busy_o         : high while a granted access is waiting for its response
// Each grant produces exactly one registered response RD_LAT+1 cycles later.
// Out-of-range addresses are granted but never touch the RAM and answer err=1.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_arbiter_if.slave     m_if,
  dmem_arbiter_if.slave     l_if,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [IDX_W-1:0]  mem_idx_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  owner_e            owner_q, owner_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic              m_rvalid_q, m_rvalid_d, l_rvalid_q, l_rvalid_d;
  logic              m_err_q, m_err_d, l_err_q, l_err_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d, l_rdata_q, l_rdata_d;

  logic              grant_m_s, grant_l_s, grant_s, addr_ok_s, sel_we_s;
  logic [63:0]       sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s, resp_data_s;

  dmem_prio_sel #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idle_i    (state_q == ST_IDLE),
    .m_req_i   (m_if.req),
    .l_req_i   (l_if.req),
    .grant_m_o (grant_m_s),
    .grant_l_o (grant_l_s)
  );

  // Route the granted requester's fields toward the RAM.
  always_comb begin
    sel_we_s    = m_if.we;
    sel_addr_s  = m_if.addr;
    sel_wdata_s = m_if.wdata;
    if (grant_l_s) begin
      sel_we_s    = l_if.we;
      sel_addr_s  = l_if.addr;
      sel_wdata_s = l_if.wdata;
    end else begin
      sel_we_s    = m_if.we;
    end
  end

  // RAM strobes: an out-of-range grant keeps the RAM untouched.
  always_comb begin
    grant_s     = grant_m_s | grant_l_s;
    addr_ok_s   = addr_in_range(sel_addr_s, MEM_BYTES);
    mem_en_o    = grant_s & addr_ok_s;
    mem_we_o    = grant_s & addr_ok_s & sel_we_s;
    mem_idx_o   = mem_en_o ? sel_addr_s[IDX_W+2:3] : {IDX_W{1'b0}};
    mem_wdata_o = mem_we_o ? sel_wdata_s : {DATA_W{1'b0}};
  end

  assign m_if.gnt    = grant_m_s;
  assign l_if.gnt    = grant_l_s;
  assign m_if.rvalid = m_rvalid_q;
  assign l_if.rvalid = l_rvalid_q;
  assign m_if.rdata  = m_rdata_q;
  assign l_if.rdata  = l_rdata_q;
  assign m_if.err    = m_err_q;
  assign l_if.err    = l_err_q;
  assign busy_o      = (state_q == ST_WAIT);

  // Writes and errors answer with zero data; only reads return the RAM word.
  assign resp_data_s = (err_q | we_q) ? {DATA_W{1'b0}} : mem_rdata_i;

  // FSM next state, latency countdown and one-cycle response formation.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    owner_d    = owner_q;
    err_d      = err_q;
    we_d       = we_q;
    m_rvalid_d = 1'b0;
    l_rvalid_d = 1'b0;
    m_err_d    = 1'b0;
    l_err_d    = 1'b0;
    m_rdata_d  = {DATA_W{1'b0}};
    l_rdata_d  = {DATA_W{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d = ST_WAIT;
          lat_d   = LAT_W'(RD_LAT);
          owner_d = grant_l_s ? OWN_L : OWN_M;
          err_d   = ~addr_ok_s;
          we_d    = sel_we_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // lat_q reaches 1 in the cycle the RAM data is valid.
        if (lat_q == LAT_W'(1)) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_L) begin
            l_rvalid_d = 1'b1;
            l_err_d    = err_q;
            l_rdata_d  = resp_data_s;
          end else begin
            m_rvalid_d = 1'b1;
            m_err_d    = err_q;
            m_rdata_d  = resp_data_s;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lat_q      <= {LAT_W{1'b0}};
      owner_q    <= OWN_M;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      m_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      m_err_q    <= 1'b0;
      l_err_q    <= 1'b0;
      m_rdata_q  <= {DATA_W{1'b0}};
      l_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      we_q       <= we_d;
      m_rvalid_q <= m_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      m_err_q    <= m_err_d;
      l_err_q    <= l_err_d;
      m_rdata_q  <= m_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

endmodule
